// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared seven-segment constants, encodings and sizing helpers
//   SEG_BLANK / SEG_MINUS : active-low {g,f,e,d,c,b,a} patterns
//   ANODES_OFF            : all anodes released (active-low), widest supported display
//   scroll_t              : offset update selected for the current cycle
//   hex_to_seg()          : hex nibble to active-low segment pattern
//   off_width()           : width of the offset register for a given digit count / window
package seg_display_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    localparam int MAX_ANODES = 16;
    localparam logic [MAX_ANODES-1:0] ANODES_OFF = '1;

    typedef enum logic [1:0] {
        SCROLL_HOLD,
        SCROLL_UP_SAT,
        SCROLL_DOWN_SAT,
        SCROLL_UP_WRAP
    } scroll_t;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // Offset can take MAXOFF+1 values; a single-value range still needs one bit.
    function automatic int off_width(input int num_digits, input int window);
        int w;
        w = $clog2(num_digits - window + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/seg_window_scroller_if.sv
// rtl/seg_window_scroller_if.sv - display-side bundle of the scrolling hex driver
//   seg    : active-low segments {g,f,e,d,c,b,a}
//   an     : active-low anodes, an[WINDOW] is the sign digit
//   offset : LS digit index currently selected for display
//   master : driven by seg_window_scroller; slave : board pins / observers
interface seg_window_scroller_if
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS = 5,
    parameter int WINDOW     = 3
);
    localparam int OFF_W = off_width(NUM_DIGITS, WINDOW);

    logic [6:0]       seg;
    logic [WINDOW:0]  an;
    logic [OFF_W-1:0] offset;

    modport master (output seg, output an, output offset);
    modport slave  (input  seg, input  an, input  offset);
endinterface

// File: rtl/seven_seg_decoder.sv
// rtl/seven_seg_decoder.sv - hex nibble to active-low seven-segment pattern
//   en  : 0 forces the blank pattern
//   num : hex digit to show
//   seg : active-low segments {g,f,e,d,c,b,a}
module seven_seg_decoder
    import seg_display_pkg::*;
(
    input  logic       en,
    input  logic [3:0] num,
    output logic [6:0] seg
);
    assign seg = en ? hex_to_seg(num) : SEG_BLANK;
endmodule

// File: rtl/seg_window_scroller.sv
// rtl/seg_window_scroller.sv - scrolling WINDOW-digit view of an N-digit hex value plus sign
//   slow_clock : scan clock (already divided)
//   reset      : asynchronous, active-high
//   btn_left   : clean level, rising edge moves the view toward MS digits
//   btn_right  : clean level, rising edge moves the view toward LS digits
//   auto_mode  : 1 = timed wrap-around scroll, buttons ignored
//   value      : hex value, digit i = value[4i+3:4i]
//   sign       : 1 = minus in the sign position
//   disp       : seg / an / offset outputs (seg_window_scroller_if.master)
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most
// significant nonzero digit of the frame snapshot (digit 0 is never blanked).
module seg_window_scroller
    import seg_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 5,
    parameter int WINDOW      = 3,
    parameter int AUTO_PERIOD = 500
)
(
    input  logic                    slow_clock,
    input  logic                    reset,
    input  logic                    btn_left,
    input  logic                    btn_right,
    input  logic                    auto_mode,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic                    sign,
    seg_window_scroller_if.master   disp
);
    localparam int MAXOFF  = NUM_DIGITS - WINDOW;
    localparam int OFF_W   = off_width(NUM_DIGITS, WINDOW);
    localparam int POS_W   = $clog2(WINDOW + 1);
    localparam int AN_W    = WINDOW + 1;
    localparam int DWELL_W = $clog2(AUTO_PERIOD);
    // Wide enough for offset+pos up to NUM_DIGITS (reached on the sign slot).
    localparam int IDX_W   = $clog2(NUM_DIGITS + 1);

    localparam logic [POS_W-1:0]   POS_LAST   = POS_W'(WINDOW);
    localparam logic [OFF_W-1:0]   OFF_MAX    = OFF_W'(MAXOFF);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(AUTO_PERIOD - 1);

    logic [POS_W-1:0]        pos_q;
    logic [OFF_W-1:0]        off_q;
    logic [DWELL_W-1:0]      dwell_q;
    logic                    prev_left_q;
    logic                    prev_right_q;
    logic [4*NUM_DIGITS-1:0] snap_value_q;
    logic                    snap_sign_q;
    logic [OFF_W-1:0]        snap_off_q;
    logic [6:0]              seg_q;
    logic [AN_W-1:0]         an_q;

    logic [POS_W-1:0]        pos_d;
    logic [OFF_W-1:0]        off_d;
    logic [DWELL_W-1:0]      dwell_d;
    logic [AN_W-1:0]         an_d;
    logic [6:0]              seg_d;
    logic                    frame_end;
    logic                    rise_left;
    logic                    rise_right;
    scroll_t                 scroll;

    logic [IDX_W-1:0]        digit_idx;
    logic [3:0]              digit;
    logic                    lz_blank;
    logic                    dec_en;
    logic [6:0]              dec_seg;

    // ---------------------------------------------------------------
    // Scan position
    // ---------------------------------------------------------------
    assign frame_end = (pos_q == POS_LAST);
    assign pos_d     = frame_end ? '0 : pos_q + 1'b1;

    // ---------------------------------------------------------------
    // Scroll control
    // ---------------------------------------------------------------
    assign rise_left  = btn_left  & ~prev_left_q;
    assign rise_right = btn_right & ~prev_right_q;

    always_comb begin
        scroll  = SCROLL_HOLD;
        dwell_d = '0;
        if (auto_mode) begin
            if (dwell_q == DWELL_LAST) begin
                scroll = SCROLL_UP_WRAP;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else if (rise_left && !rise_right) begin
            scroll = SCROLL_UP_SAT;
        end else if (rise_right && !rise_left) begin
            scroll = SCROLL_DOWN_SAT;
        end
    end

    always_comb begin
        off_d = off_q;
        case (scroll)
            SCROLL_UP_SAT:   if (off_q != OFF_MAX) off_d = off_q + 1'b1;
            SCROLL_DOWN_SAT: if (off_q != '0)      off_d = off_q - 1'b1;
            SCROLL_UP_WRAP:  off_d = (off_q == OFF_MAX) ? '0 : off_q + 1'b1;
            default:         off_d = off_q;
        endcase
    end

    // ---------------------------------------------------------------
    // Digit selection from the frame snapshot
    // ---------------------------------------------------------------
    assign digit_idx = IDX_W'(snap_off_q) + IDX_W'(pos_q);

    always_comb begin
        digit = 4'h0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) begin
                digit = snap_value_q[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_idx;

    // Highest nonzero nibble; stays 0 for an all-zero value so digit 0 shows.
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (snap_value_q[4*i +: 4] != 4'h0) begin
                msd_idx = IDX_W'(i);
            end
        end
    end

    assign lz_blank = (digit_idx > msd_idx);
`else
    assign lz_blank = 1'b0;
`endif

    assign dec_en = !frame_end && !lz_blank;

    seven_seg_decoder u_decoder (
        .en  (dec_en),
        .num (digit),
        .seg (dec_seg)
    );

    // The sign slot closes the frame, so it uses the same snapshot as the digits.
    assign seg_d = frame_end ? (snap_sign_q ? SEG_MINUS : SEG_BLANK) : dec_seg;
    assign an_d  = ~(AN_W'(1) << pos_q);

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            pos_q        <= '0;
            off_q        <= '0;
            dwell_q      <= '0;
            prev_left_q  <= 1'b0;
            prev_right_q <= 1'b0;
            snap_value_q <= '0;
            snap_sign_q  <= 1'b0;
            snap_off_q   <= '0;
            seg_q        <= SEG_BLANK;
            an_q         <= ANODES_OFF[AN_W-1:0];
        end else begin
            pos_q        <= pos_d;
            off_q        <= off_d;
            dwell_q      <= dwell_d;
            prev_left_q  <= btn_left;
            prev_right_q <= btn_right;
            seg_q        <= seg_d;
            an_q         <= an_d;
            // Capture at the last slot so the next frame is drawn from one consistent set.
            if (frame_end) begin
                snap_value_q <= value;
                snap_sign_q  <= sign;
                snap_off_q   <= off_q;
            end
        end
    end

    assign disp.seg    = seg_q;
    assign disp.an     = an_q;
    assign disp.offset = off_q;

endmodule
